// File: rtl/rr_arb_mux.sv
// N-channel valid/ready arbiter feeding a single registered output stage.
// Round-robin or fixed-priority grant; accepts a new beat in the same cycle the held one drains.
module rr_arb_mux #(
   parameter int N       = 8,
   parameter int W       = 8,
   parameter bit RR_MODE = 1'b1,
   parameter int SEL_W   = (N > 1) ? $clog2(N) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     in_valid,
   input  logic [N*W-1:0]   in_data,
   output logic [N-1:0]     in_ready,
   output logic             out_valid,
   output logic [W-1:0]     out_data,
   output logic [SEL_W-1:0] out_sel,
   input  logic             out_ready
);

   logic [SEL_W-1:0] ptr;
   logic [SEL_W-1:0] gnt_idx;
   logic             gnt_any;
   logic [W-1:0]     gnt_data;
   logic             load;
   logic             xfer;
   logic [SEL_W:0]   scan;
   logic [SEL_W-1:0] scan_idx;

   assign load = ~out_valid | out_ready;
   assign xfer = rst_n & load & gnt_any;

   // Scan one extra bit wide so ptr+k never overflows before the modulo fold.
   always_comb begin
      gnt_any  = 1'b0;
      gnt_idx  = '0;
      scan     = '0;
      scan_idx = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (RR_MODE)
            scan = {1'b0, ptr} + (SEL_W+1)'(k);
         else
            scan = (SEL_W+1)'(k);
         if (scan >= (SEL_W+1)'(N))
            scan = scan - (SEL_W+1)'(N);
         scan_idx = scan[SEL_W-1:0];
         if (!gnt_any && in_valid[scan_idx]) begin
            gnt_any = 1'b1;
            gnt_idx = scan_idx;
         end
      end
   end

   always_comb begin
      gnt_data = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (gnt_idx == SEL_W'(k))
            gnt_data = in_data[k*W +: W];
      end
   end

   always_comb begin
      in_ready = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (xfer && gnt_idx == SEL_W'(k))
            in_ready[k] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
         ptr       <= '0;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= gnt_data;
         out_sel   <= gnt_idx;
         if (RR_MODE) begin
            if (gnt_idx == SEL_W'(N-1))
               ptr <= '0;
            else
               ptr <= gnt_idx + 1'b1;
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Randomised and directed bench for rr_arb_mux; round-robin and fixed-priority
// instances share stimulus and are checked against an abstract model.
module tb_rr_arb_mux;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  in_valid;
   logic [63:0] in_data;
   logic        out_ready;

   logic [7:0]  ir_rr, ir_fp;
   logic        ov_rr, ov_fp;
   logic [7:0]  od_rr, od_fp;
   logic [2:0]  os_rr, os_fp;

   rr_arb_mux #(.N(8), .W(8), .RR_MODE(1'b1)) dut_rr (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_ready(ir_rr), .out_valid(ov_rr), .out_data(od_rr), .out_sel(os_rr),
      .out_ready(out_ready));

   rr_arb_mux #(.N(8), .W(8), .RR_MODE(1'b0)) dut_fp (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_ready(ir_fp), .out_valid(ov_fp), .out_data(od_fp), .out_sel(os_fp),
      .out_ready(out_ready));

   always #5 clk = ~clk;

   logic [19:0] obs_rr, obs_fp, exp_rr, exp_fp;
   assign obs_rr = {ir_rr, ov_rr, od_rr, os_rr};
   assign obs_fp = {ir_fp, ov_fp, od_fp, os_fp};

   int checks   = 0;
   int failures = 0;

   // Model state: index 0 = round-robin instance, 1 = fixed-priority instance.
   int mv[2], md[2], ms[2], mptr[2], gc[2];
   bit fire[2];

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         mv[m] = 0; md[m] = 0; ms[m] = 0; mptr[m] = 0;
      end
   endtask

   task automatic drive(input logic r, input logic [7:0] v, input logic [63:0] d, input logic ordy);
      logic [19:0] e[2];
      bit          found;
      int          c;
      rst_n = r; in_valid = v; in_data = d; out_ready = ordy;
      if (!r) model_reset();
      #1;
      for (int m = 0; m < 2; m++) begin
         found = 0; gc[m] = 0;
         for (int k = 0; k < 8; k++) begin
            c = (m == 0) ? (mptr[m] + k) % 8 : k;
            if (!found && v[c]) begin found = 1; gc[m] = c; end
         end
         fire[m] = r && found && (mv[m] == 0 || ordy);
         e[m] = {fire[m] ? 8'(1 << gc[m]) : 8'h00, mv[m] != 0, 8'(md[m]), 3'(ms[m])};
      end
      exp_rr = e[0];
      exp_fp = e[1];
   endtask

   task automatic step();
      @(posedge clk);
      if (rst_n) begin
         for (int m = 0; m < 2; m++) begin
            if (fire[m]) begin
               mv[m] = 1; md[m] = int'(in_data[gc[m]*8 +: 8]); ms[m] = gc[m];
               mptr[m] = (gc[m] + 1) % 8;
            end else if (mv[m] != 0 && out_ready) begin
               mv[m] = 0;
            end
         end
      end
      #1;
   endtask

   function automatic logic [63:0] seq_data();
      logic [63:0] d;
      for (int i = 0; i < 8; i++) d[i*8 +: 8] = 8'(8'h10 + i);
      return d;
   endfunction

   task automatic test_reset();
      drive(1'b0, 8'hFF, {$urandom, $urandom}, 1'b1);
      checks += 2;
      if (obs_rr !== 20'h0) begin failures++; $display("FAIL reset_rr got=%h exp=%h", obs_rr, 20'h0); end
      if (obs_fp !== 20'h0) begin failures++; $display("FAIL reset_fp got=%h exp=%h", obs_fp, 20'h0); end
      step();
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 8'h00, {$urandom, $urandom}, 1'b1);
         checks += 2;
         if (obs_rr !== exp_rr || ov_rr !== 1'b0) begin failures++; $display("FAIL idle_rr got=%h exp=%h", obs_rr, exp_rr); end
         if (obs_fp !== exp_fp || ov_fp !== 1'b0) begin failures++; $display("FAIL idle_fp got=%h exp=%h", obs_fp, exp_fp); end
         step();
      end
   endtask

   task automatic test_single_latency();
      logic [63:0] d;
      d = {$urandom, $urandom};
      d[5*8 +: 8] = 8'hA5;
      drive(1'b1, 8'b0010_0000, d, 1'b1);
      checks++;
      if (ir_rr !== 8'b0010_0000) begin failures++; $display("FAIL single_ready got=%b exp=%b", ir_rr, 8'b0010_0000); end
      step();
      drive(1'b1, 8'h00, d, 1'b1);
      checks++;
      if ({ov_rr, od_rr, os_rr} !== {1'b1, 8'hA5, 3'd5}) begin
         failures++; $display("FAIL single_out got=%b/%h/%0d exp=1/a5/5", ov_rr, od_rr, os_rr);
      end
      step();
      drive(1'b1, 8'h00, d, 1'b1);
      checks++;
      if (ov_rr !== 1'b0) begin failures++; $display("FAIL single_drain got=%b exp=0", ov_rr); end
      step();
      // Pointer should now sit at 6: with all channels requesting, 6 wins in RR mode.
      drive(1'b1, 8'hFF, d, 1'b1);
      checks += 2;
      if (ir_rr !== 8'b0100_0000) begin failures++; $display("FAIL single_ptr got=%b exp=%b", ir_rr, 8'b0100_0000); end
      if (obs_fp !== exp_fp) begin failures++; $display("FAIL single_fp got=%h exp=%h", obs_fp, exp_fp); end
      step();
      drive(1'b1, 8'h00, d, 1'b1);
      step();
      drive(1'b1, 8'h00, d, 1'b1);
      step();
   endtask

   task automatic test_rr_fairness();
      logic [7:0] seen;
      model_reset();
      drive(1'b0, 8'h00, 64'h0, 1'b1);
      step();
      seen = 8'h00;
      for (int i = 0; i < 11; i++) begin
         drive(1'b1, 8'hFF, seq_data(), 1'b1);
         checks += 2;
         if (obs_rr !== exp_rr) begin failures++; $display("FAIL rr_seq cyc=%0d got=%h exp=%h", i, obs_rr, exp_rr); end
         if (i >= 1 && os_rr !== 3'((i - 1) % 8)) begin
            failures++; $display("FAIL rr_order cyc=%0d got=%0d exp=%0d", i, os_rr, (i - 1) % 8);
         end
         if (i < 8) seen |= ir_rr;
         step();
      end
      checks++;
      if (seen !== 8'hFF) begin failures++; $display("FAIL rr_fair got=%b exp=%b", seen, 8'hFF); end
   endtask

   task automatic test_fixed_priority();
      for (int i = 0; i < 9; i++) begin
         drive(1'b1, (i < 6) ? 8'b0100_0100 : 8'b0100_0000, seq_data(), 1'b1);
         checks += 2;
         if (ir_fp !== ((i < 6) ? 8'b0000_0100 : 8'b0100_0000)) begin
            failures++; $display("FAIL fp_grant cyc=%0d got=%b", i, ir_fp);
         end
         if (obs_fp !== exp_fp) begin failures++; $display("FAIL fp_model cyc=%0d got=%h exp=%h", i, obs_fp, exp_fp); end
         step();
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] held_d;
      logic [2:0] held_s;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 8'b0000_1010, {$urandom, $urandom}, !(i >= 1 && i <= 4));
         checks += 2;
         if (obs_rr !== exp_rr) begin failures++; $display("FAIL bp_rr cyc=%0d got=%h exp=%h", i, obs_rr, exp_rr); end
         if (obs_fp !== exp_fp) begin failures++; $display("FAIL bp_fp cyc=%0d got=%h exp=%h", i, obs_fp, exp_fp); end
         if (i == 1) begin held_d = od_rr; held_s = os_rr; end
         if (i >= 2 && i <= 4) begin
            checks++;
            if ({ir_rr, od_rr, os_rr} !== {8'h00, held_d, held_s}) begin
               failures++; $display("FAIL bp_hold cyc=%0d got=%b/%h/%0d", i, ir_rr, od_rr, os_rr);
            end
         end
         step();
      end
   endtask

   task automatic test_random();
      logic [7:0] v;
      for (int i = 0; i < 400; i++) begin
         v = 8'($urandom) & 8'($urandom);
         drive(($urandom_range(0, 99) != 0), v, {$urandom, $urandom}, ($urandom_range(0, 9) < 7));
         checks += 2;
         if (obs_rr !== exp_rr) begin failures++; $display("FAIL rand_rr cyc=%0d got=%h exp=%h", i, obs_rr, exp_rr); end
         if (obs_fp !== exp_fp) begin failures++; $display("FAIL rand_fp cyc=%0d got=%h exp=%h", i, obs_fp, exp_fp); end
         step();
      end
   endtask

   task automatic test_reset_midstream();
      model_reset();
      drive(1'b0, 8'h00, 64'h0, 1'b1);
      step();
      drive(1'b1, 8'b0001_0000, seq_data(), 1'b1);
      step();
      drive(1'b1, 8'h00, seq_data(), 1'b0);
      checks++;
      if ({ov_rr, os_rr} !== {1'b1, 3'd4}) begin failures++; $display("FAIL mid_pre got=%b/%0d exp=1/4", ov_rr, os_rr); end
      #2;
      drive(1'b0, 8'hFF, seq_data(), 1'b1);
      checks += 2;
      if (obs_rr !== 20'h0) begin failures++; $display("FAIL mid_async_rr got=%h exp=%h", obs_rr, 20'h0); end
      if (obs_fp !== 20'h0) begin failures++; $display("FAIL mid_async_fp got=%h exp=%h", obs_fp, 20'h0); end
      step();
      drive(1'b1, 8'hFF, seq_data(), 1'b1);
      checks++;
      if (ir_rr !== 8'b0000_0001) begin failures++; $display("FAIL mid_first_grant got=%b exp=%b", ir_rr, 8'b0000_0001); end
      step();
      drive(1'b1, 8'h00, seq_data(), 1'b1);
      checks++;
      if (obs_rr !== exp_rr || os_rr !== 3'd0) begin failures++; $display("FAIL mid_first_sel got=%h exp=%h", obs_rr, exp_rr); end
      step();
   endtask

   initial begin
      rst_n = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0;
      model_reset();
      #2;
      test_reset();
      test_single_latency();
      test_rr_fairness();
      test_fixed_priority();
      test_backpressure();
      test_random();
      test_reset_midstream();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
